// File: rtl/pipelined_addsub_pkg.sv
// Shared definitions for the carry-segmented add/subtract datapath blocks.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Width of one carry segment; guarded so a bad STAGES value reaches the
  // elaboration check instead of dividing by zero.
  function automatic int seg_width(input int width, input int stages);
    return (stages > 0) ? (width / stages) : width;
  endfunction

endpackage

// File: rtl/pipelined_addsub_adder_segment.sv
// One carry segment: SEG_W-bit adder with carry-in, carry-out and carry into its MSB.
module adder_segment #(
  parameter int SEG_W = 4
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [SEG_W:0] full_s;

  assign full_s = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};
  assign sum    = full_s[SEG_W-1:0];
  assign cout   = full_s[SEG_W];
  // Carry into the MSB recovered from the MSB sum bit and its operands.
  assign cmsb   = a[SEG_W-1] ^ b[SEG_W-1] ^ full_s[SEG_W-1];

endmodule

// File: rtl/pipelined_addsub.sv
// WIDTH-bit add/subtract split into STAGES carry segments with registered
// carries, operand skew and result deskew; result valid STAGES cycles later.
`ifndef WIDTH
`define WIDTH 16
`endif

module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH           = `WIDTH,
  parameter int STAGES          = 4,
  parameter bit VALID_IS_ENABLE = 1'b1
) (
  input  logic             clk_i,
  input  logic             rstn,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_o,
  output logic             ovf_o,
  output logic             valid_o
);

  localparam int SEG_W = seg_width(WIDTH, STAGES);

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $fatal(1, "pipelined_addsub: STAGES must be >= 1 and divide WIDTH");
  end

  // Subtract as A + ~B + 1: inversion and carry-in both applied at entry.
  logic [WIDTH-1:0] b_eff_s;
  logic             cin0_s;

  assign b_eff_s = (sub_i == OP_ADD) ? b_i : ~b_i;
  assign cin0_s  = (sub_i == OP_SUB);

  for (genvar k = 0; k < STAGES; k++) begin : stg
    logic [SEG_W-1:0]         a_seg_s;
    logic [SEG_W-1:0]         b_seg_s;
    logic [SEG_W-1:0]         s_seg_s;
    logic                     cin_s;
    logic                     vin_s;
    logic                     load_s;
    logic                     cout_s;
    logic                     cmsb_s;
    logic [(k+1)*SEG_W-1:0]   sum_d_s;
    logic                     vld_r;
    logic                     cy_r;
    logic [(k+1)*SEG_W-1:0]   sum_r;

    if (k == 0) begin : src
      assign a_seg_s = a_i[SEG_W-1:0];
      assign b_seg_s = b_eff_s[SEG_W-1:0];
      assign cin_s   = cin0_s;
      assign vin_s   = valid_i;
      assign sum_d_s = s_seg_s;
    end else begin : src
      assign a_seg_s = stg[k-1].mid.a_r[SEG_W-1:0];
      assign b_seg_s = stg[k-1].mid.b_r[SEG_W-1:0];
      assign cin_s   = stg[k-1].cy_r;
      assign vin_s   = stg[k-1].vld_r;
      assign sum_d_s = {s_seg_s, stg[k-1].sum_r};
    end

    assign load_s = !VALID_IS_ENABLE || vin_s;

    adder_segment #(.SEG_W(SEG_W)) u_seg (
      .a    (a_seg_s),
      .b    (b_seg_s),
      .cin  (cin_s),
      .sum  (s_seg_s),
      .cout (cout_s),
      .cmsb (cmsb_s)
    );

    // Valid always shifts; carry and accumulated lower slices load on enable.
    always_ff @(posedge clk_i or negedge rstn) begin
      if (!rstn) begin
        vld_r <= 1'b0;
        cy_r  <= 1'b0;
        sum_r <= '0;
      end else begin
        vld_r <= vin_s;
        if (load_s) begin
          cy_r  <= cout_s;
          sum_r <= sum_d_s;
        end
      end
    end

    if (k < STAGES-1) begin : mid
      localparam int UP_W = WIDTH - (k+1)*SEG_W;
      logic [UP_W-1:0] a_d_s;
      logic [UP_W-1:0] b_d_s;
      logic [UP_W-1:0] a_r;
      logic [UP_W-1:0] b_r;
      logic            cmsb_unused;

      // Only the top segment's MSB carry matters for overflow.
      assign cmsb_unused = cmsb_s;

      if (k == 0) begin : up
        assign a_d_s = a_i[WIDTH-1:SEG_W];
        assign b_d_s = b_eff_s[WIDTH-1:SEG_W];
      end else begin : up
        assign a_d_s = stg[k-1].mid.a_r[WIDTH-k*SEG_W-1:SEG_W];
        assign b_d_s = stg[k-1].mid.b_r[WIDTH-k*SEG_W-1:SEG_W];
      end

      // Skew registers carry the not-yet-added upper operand slices.
      always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
          a_r <= '0;
          b_r <= '0;
        end else if (load_s) begin
          a_r <= a_d_s;
          b_r <= b_d_s;
        end
      end
    end else begin : last
      logic ovf_r;

      // Signed overflow: carry into MSB differs from carry out of MSB.
      always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
          ovf_r <= 1'b0;
        end else if (load_s) begin
          ovf_r <= cout_s ^ cmsb_s;
        end
      end
    end
  end

  assign sum_o   = stg[STAGES-1].sum_r;
  assign c_o     = stg[STAGES-1].cy_r;
  assign ovf_o   = stg[STAGES-1].last.ovf_r;
  assign valid_o = stg[STAGES-1].vld_r;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench: a 4-stage and a 1-stage instance driven with the same
// stream; expected results come from plain integer arithmetic.
module tb_pipelined_addsub;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] sum;
    logic         c;
    logic         ovf;
    int           due;
  } exp_t;

  logic         clk  = 1'b0;
  logic         rstn = 1'b0;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         sub_in;
  logic         vin;
  logic [W-1:0] so  [2];
  logic         co  [2];
  logic         ovo [2];
  logic         vo  [2];

  exp_t sb [2][$];
  exp_t last [2];
  int   lat [2] = '{4, 1};
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  pipelined_addsub #(.WIDTH(W), .STAGES(4), .VALID_IS_ENABLE(1'b1)) dut4 (
    .clk_i(clk), .rstn(rstn), .a_i(a_in), .b_i(b_in), .sub_i(sub_in), .valid_i(vin),
    .sum_o(so[0]), .c_o(co[0]), .ovf_o(ovo[0]), .valid_o(vo[0])
  );

  pipelined_addsub #(.WIDTH(W), .STAGES(1), .VALID_IS_ENABLE(1'b1)) dut1 (
    .clk_i(clk), .rstn(rstn), .a_i(a_in), .b_i(b_in), .sub_i(sub_in), .valid_i(vin),
    .sum_o(so[1]), .c_o(co[1]), .ovf_o(ovo[1]), .valid_o(vo[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic, no bit-level carries.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input int due);
    exp_t        m;
    int          sa, sb_v, r;
    int unsigned ua, ub;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb_v = $signed(b);
    if (sub) begin
      r     = sa - sb_v;
      m.c   = (ua >= ub);
      m.sum = W'(ua - ub);
    end else begin
      r     = sa + sb_v;
      m.c   = ((ua + ub) > 32'd65535);
      m.sum = W'(ua + ub);
    end
    m.ovf = (r > 32767) || (r < -32768);
    m.due = due;
    return m;
  endfunction

  // Monitor: pop on valid_o; otherwise outputs must hold the last result.
  always @(negedge clk) begin : mon
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (vo[d]) begin
        if (sb[d].size() == 0 || sb[d][0].due != cyc) begin
          chk($sformatf("unexpected_valid_s%0d", lat[d]), 32'(vo[d]), 32'd0);
        end else begin
          e = sb[d].pop_front();
          chk($sformatf("sum_s%0d", lat[d]), 32'(so[d]), 32'(e.sum));
          chk($sformatf("carry_s%0d", lat[d]), 32'(co[d]), 32'(e.c));
          chk($sformatf("ovf_s%0d", lat[d]), 32'(ovo[d]), 32'(e.ovf));
          last[d] = e;
        end
      end else begin
        if (sb[d].size() > 0 && sb[d][0].due == cyc) begin
          chk($sformatf("missing_valid_s%0d", lat[d]), 32'(vo[d]), 32'd1);
          e = sb[d].pop_front();
        end
        chk($sformatf("hold_sum_s%0d", lat[d]), 32'(so[d]), 32'(last[d].sum));
        chk($sformatf("hold_carry_s%0d", lat[d]), 32'(co[d]), 32'(last[d].c));
        chk($sformatf("hold_ovf_s%0d", lat[d]), 32'(ovo[d]), 32'(last[d].ovf));
      end
    end
  end

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts);
    a_in   = ta;
    b_in   = tb;
    sub_in = ts;
    vin    = 1'b1;
    for (int d = 0; d < 2; d++) sb[d].push_back(model(ta, tb, ts, cyc + lat[d]));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    vin = 1'b0;
    for (int i = 0; i < n; i++) begin
      a_in   = W'($urandom);
      b_in   = W'($urandom);
      sub_in = 1'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] corners [5];
    int sel;
    corners = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001};
    sel = $urandom_range(0, 9);
    return (sel < 5) ? corners[sel] : W'($urandom);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a_in   = '0;
    b_in   = '0;
    sub_in = 1'b0;
    vin    = 1'b0;
    for (int d = 0; d < 2; d++) last[d] = '{sum: '0, c: 1'b0, ovf: 1'b0, due: 0};
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_valid", 32'(vo[d]), 32'd0);
      chk("reset_sum", 32'(so[d]), 32'd0);
    end
    rstn = 1'b1;
    idle(2);

    send(16'h00FF, 16'h0001, 1'b0); idle(6);
    send(16'hFFFF, 16'h0001, 1'b0); idle(5);
    send(16'h7FFF, 16'h0001, 1'b0); idle(5);
    send(16'h8000, 16'h0001, 1'b1); idle(5);
    send(16'h0003, 16'h0005, 1'b1); idle(5);
    send(16'h0001, 16'h0002, 1'b0);
    send(16'h000A, 16'h0003, 1'b1);
    send(16'hFFFF, 16'hFFFF, 1'b0);
    send(16'h0000, 16'h0000, 1'b1);
    idle(6);
    send(16'h1234, 16'h1111, 1'b0); idle(6);

    // Reset with transactions in flight, asserted mid-cycle.
    send(pick(), pick(), 1'b0);
    send(pick(), pick(), 1'b1);
    send(pick(), pick(), 1'b0);
    #2;
    rstn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      sb[d].delete();
      last[d] = '{sum: '0, c: 1'b0, ovf: 1'b0, due: 0};
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("midreset_valid", 32'(vo[d]), 32'd0);
      chk("midreset_sum", 32'(so[d]), 32'd0);
      chk("midreset_carry", 32'(co[d]), 32'd0);
      chk("midreset_ovf", 32'(ovo[d]), 32'd0);
    end
    @(posedge clk);
    #1;
    vin    = 1'b1;
    a_in   = 16'hABCD;
    b_in   = 16'h5555;
    @(posedge clk);
    #1;
    vin  = 1'b0;
    rstn = 1'b1;
    idle(6);
    send(16'h00FF, 16'h0001, 1'b0); idle(6);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      else send(pick(), pick(), 1'($urandom));
    end
    idle(8);
    for (int d = 0; d < 2; d++) chk("drain_empty", 32'(sb[d].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised successor to the single-cycle adder-plus-register top level.
- Performs WIDTH-bit add or subtract, selectable per transaction, in a carry-segmented pipeline of STAGES stages.
- Each stage resolves one SEG_W = WIDTH/STAGES slice; carry is registered between slices, so WIDTH scales without a long carry chain.
- Emits sum, carry-out and signed overflow with a matching valid, STAGES cycles after input.

Parameters:
- WIDTH, `WIDTH: operand/result width in bits; must be divisible by STAGES.
- STAGES, 4: pipeline depth; 1 = single registered adder.
- VALID_IS_ENABLE, 1: 1 = stage registers load only when that stage's valid is high (outputs hold last result); 0 = load every cycle.

Ports:
- clk_i  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- a_i  in  WIDTH  operand A.
- b_i  in  WIDTH  operand B.
- sub_i  in  1  0 = A+B, 1 = A-B; sampled with valid_i.
- valid_i  in  1  input transaction valid; no backpressure; accepted every cycle it is high.
- sum_o  out  WIDTH  result, modulo 2^WIDTH.
- c_o  out  1  carry-out of MSB. For subtract, 1 = no borrow.
- ovf_o  out  1  two's-complement signed overflow.
- valid_o  out  1  result valid.

Behaviour:
- Subtract is implemented as A + ~B + 1: B inverted and carry-in = sub_i, both in stage 0.
- Stage k (0..STAGES-1):
  - adds slice k of A and B' plus the registered carry from stage k-1 (stage 0 uses sub_i);
  - registers the slice sum, carry-out and valid.
- Operand slices above k are delayed through skew registers until their stage.
- Finished lower slices are delayed through deskew registers so all slices of one transaction reach sum_o together.
- Latency: exactly STAGES cycles from a valid_i sample to valid_o. Throughput is one transaction per cycle. Order is preserved.
- c_o is the carry-out of the top slice.
- ovf_o = carry into MSB XOR carry out of MSB, computed in the last stage.
- valid_o is a STAGES-deep shift of valid_i and is never gated by data.
- VALID_IS_ENABLE=1:
  - data/carry registers of a stage load only when that stage's incoming valid is 1;
  - when valid_o = 0, sum_o/c_o/ovf_o hold the last valid result.
- VALID_IS_ENABLE=0:
  - all data registers load every cycle;
  - outputs are don't-care when valid_o = 0 but must be deterministic (no X after reset).
- Reset (rstn low, asynchronous):
  - all valid, data, carry, skew and deskew registers clear to 0 immediately;
  - sum_o=0, c_o=0, ovf_o=0, valid_o=0.
- Reset mid-operation: in-flight transactions are discarded. No stale valid_o after rstn deasserts. The first valid_o appears STAGES cycles after the first post-reset valid_i.
- valid_i sampled high while rstn is low is ignored.
- Wrap-around: sum is modulo 2^WIDTH, with overflow reported only via c_o/ovf_o. No saturation.
- STAGES=1: SEG_W = WIDTH; behaviour equals a registered add/sub with latency 1.
- Elaboration checks: WIDTH % STAGES != 0 or STAGES < 1 is a fatal error.

Decomposition:
- Shared package addsub_pkg:
  - localparams OP_ADD=1'b0 and OP_SUB=1'b1;
  - a function for SEG_W derivation, reused by other datapath blocks.
- One sub-module, adder_segment:
  - SEG_W-bit combinational adder with carry-in/carry-out and MSB-carry-in output;
  - instantiated STAGES times via generate.
- Skew/deskew registers are a generate loop in the parent. The existing register module with VALID_IS_ENABLE may be reused for them.

Test Plan (WIDTH=16, STAGES=4 unless noted):
- Slice-boundary carry: a=0x00FF, b=0x0001, sub=0, valid=1 for one cycle -> 4 cycles later valid_o=1, sum_o=0x0100, c_o=0, ovf_o=0; valid_o low on surrounding cycles.
- Full carry ripple across all stages: a=0xFFFF, b=0x0001, add -> sum_o=0x0000, c_o=1, ovf_o=0. Also a=0x7FFF, b=0x0001 -> sum_o=0x8000, c_o=0, ovf_o=1.
- Subtract: a=0x8000, b=0x0001, sub=1 -> sum_o=0x7FFF, c_o=1, ovf_o=1. Also a=0x0003, b=0x0005, sub=1 -> sum_o=0xFFFE, c_o=0, ovf_o=0.
- Back-to-back mixed ops on 4 consecutive cycles: (1+2 add), (10-3 sub), (0xFFFF+0xFFFF add), (0-0 sub) -> valid_o high for 4 consecutive cycles with sum_o 0x0003, 0x0007, 0xFFFE (c_o=1), 0x0000 (c_o=1), in order.
- VALID_IS_ENABLE=1 gaps: inputs 0x1234+0x1111, then 3 idle cycles -> sum_o=0x2345 appears with valid_o=1, then holds 0x2345 while valid_o=0.
- Reset mid-flight: 3 transactions in pipe, pulse rstn low asynchronously mid-cycle -> valid_o and all outputs 0 immediately. After release, no valid_o until 4 cycles after the next valid_i. Repeat the add-boundary case with STAGES=1 -> result in 1 cycle.
